// File: rtl/alu_multicycle.sv
// alu_multicycle: clocked execute-stage ALU.
// AND/OR/ADD/SUB/SLT complete in one cycle. MUL/DIVU/REMU run iteratively
// for WIDTH cycles when the ALU_MULDIV_EN macro is defined; without it those
// opcodes behave as AND and busy is held low.
// result/zero are registered and only change in the cycle done pulses.
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       ALUcontrol,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy,
    output logic             done
);

`ifdef ALU_MULDIV_EN
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
`else
    typedef enum logic {IDLE = 1'b0, DONE = 1'b1} state_t;
`endif

    state_t           state_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             done_q;
    logic [WIDTH-1:0] alu_d;

`ifdef ALU_MULDIV_EN
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // op_q: 00 MUL, 01 DIVU, 10 REMU (low bits of the accepted opcode)
    logic [1:0]       op_q;
    logic [CW-1:0]    count_q;
    logic             busy_q;
    // acc_q: product accumulator (MUL) or partial remainder (DIVU/REMU)
    // opA_q: shifting multiplicand (MUL) or dividend turning into quotient
    // opB_q: shifting multiplier (MUL) or fixed divisor
    logic [WIDTH-1:0] acc_q, opA_q, opB_q;
    logic [WIDTH-1:0] acc_d, opA_d, opB_d, final_d;
    logic [WIDTH:0]   remShift;
    logic [WIDTH-1:0] remDiff;
    logic             isIter;
    logic             lastStep;

    assign isIter   = (ALUcontrol == 4'b1000) || (ALUcontrol == 4'b1001) ||
                      (ALUcontrol == 4'b1010);
    assign lastStep = (count_q == CW'(WIDTH - 1));

    // One iteration step: shift-add for MUL, restoring shift-subtract for
    // DIVU/REMU. The remainder is always below the divisor (or equals the
    // shifted-in dividend when dividing by zero), so WIDTH bits hold it; only
    // the shifted candidate needs the extra bit for the comparison.
    always_comb begin
        remShift = {acc_q, opA_q[WIDTH-1]};
        remDiff  = remShift[WIDTH-1:0] - opB_q;
        acc_d    = acc_q;
        opA_d    = opA_q;
        opB_d    = opB_q;
        if (op_q == 2'b00) begin
            acc_d = acc_q + (opB_q[0] ? opA_q : '0);
            opA_d = opA_q << 1;
            opB_d = opB_q >> 1;
        end else if (remShift >= {1'b0, opB_q}) begin
            acc_d = remDiff;
            opA_d = {opA_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_d = remShift[WIDTH-1:0];
            opA_d = {opA_q[WIDTH-2:0], 1'b0};
        end
        final_d = (op_q == 2'b01) ? opA_d : acc_d;
    end

    assign busy = busy_q;
`else
    assign busy = 1'b0;
`endif

    // Single-cycle operations, evaluated straight from the request inputs.
    always_comb begin
        alu_d = in1 & in2;
        case (ALUcontrol)
            4'b0001: alu_d = in1 | in2;
            4'b0010: alu_d = in1 + in2;
            4'b0110: alu_d = in1 - in2;
            4'b0111: alu_d = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
            default: alu_d = in1 & in2;
        endcase
    end

    // Control FSM plus all registered outputs and iteration state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            result_q <= '0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
`ifdef ALU_MULDIV_EN
            busy_q   <= 1'b0;
            count_q  <= '0;
            op_q     <= 2'b00;
            acc_q    <= '0;
            opA_q    <= '0;
            opB_q    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
`ifdef ALU_MULDIV_EN
                RUN: begin
                    acc_q   <= acc_d;
                    opA_q   <= opA_d;
                    opB_q   <= opB_d;
                    count_q <= count_q + 1'b1;
                    if (lastStep) begin
                        result_q <= final_d;
                        zero_q   <= (final_d == '0);
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= DONE;
                    end
                end
`endif
                default: begin
                    if (start) begin
`ifdef ALU_MULDIV_EN
                        if (isIter) begin
                            op_q    <= ALUcontrol[1:0];
                            acc_q   <= '0;
                            opA_q   <= in1;
                            opB_q   <= in2;
                            count_q <= '0;
                            busy_q  <= 1'b1;
                            state_q <= RUN;
                        end else
`endif
                        begin
                            result_q <= alu_d;
                            zero_q   <= (alu_d == '0);
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign result = result_q;
    assign zero   = zero_q;
    assign done   = done_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard testbench for alu_multicycle (WIDTH = 32).
// The driver pushes the expected response whenever it issues an accepted
// request; an independent monitor pops and compares on every done pulse and
// checks that result/zero hold in between. Expected values come from plain
// arithmetic on the operands, honouring ALU_MULDIV_EN the same way the
// design build does.
module tb_alu_multicycle;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [3:0]   ALUcontrol;
    logic [W-1:0] in1, in2;
    logic [W-1:0] result;
    logic         zero, busy, done;

    typedef struct {
        logic [W-1:0] res;
        logic         zf;
        int           issue;
        int           lat;
        logic [3:0]   op;
    } expect_t;

    expect_t      expQ[$];
    int           total = 0;
    int           bad = 0;
    int           cycleCnt = 0;
    bit           rstAtEdge = 1'b0;
    logic [W-1:0] lastRes = '0;
    logic         lastZero = 1'b1;

    alu_multicycle #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .ALUcontrol(ALUcontrol),
        .in1(in1), .in2(in2), .result(result), .zero(zero),
        .busy(busy), .done(done)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Cycle counter for latency measurement and a record of reset at each edge.
    always @(posedge clk) begin
        cycleCnt  <= cycleCnt + 1;
        rstAtEdge <= rst;
    end

    function automatic bit isIterOp(input logic [3:0] op);
`ifdef ALU_MULDIV_EN
        return (op == 4'd8) || (op == 4'd9) || (op == 4'd10);
`else
        return 1'b0;
`endif
    endfunction

    // Reference behaviour from plain arithmetic on the operands.
    function automatic logic [W-1:0] refModel(input logic [3:0] op,
                                              input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        logic [2*W-1:0] prod;
        prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        case (op)
            4'd1: return a | b;
            4'd2: return a + b;
            4'd6: return a - b;
            4'd7: return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
`ifdef ALU_MULDIV_EN
            4'd8: return prod[W-1:0];
            4'd9: return (b == 0) ? '1 : a / b;
            4'd10: return (b == 0) ? a : a % b;
`endif
            default: return a & b;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, wanted %0h (cycle %0d)",
                     name, act, exp, cycleCnt);
        end
    endtask

    // Monitor: reset values, completions against the scoreboard, and holds.
    always @(negedge clk) begin : monitor
        expect_t e;
        if (rstAtEdge) begin
            checkOutput("rst_result", 64'(result), 64'(0));
            checkOutput("rst_zero", 64'(zero), 64'(1));
            checkOutput("rst_busy", 64'(busy), 64'(0));
            checkOutput("rst_done", 64'(done), 64'(0));
            expQ.delete();
            lastRes  = '0;
            lastZero = 1'b1;
        end else if (done === 1'b1) begin
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_done: got done=1, wanted no completion (cycle %0d)",
                         cycleCnt);
            end else begin
                e = expQ.pop_front();
                checkOutput($sformatf("result_op%0h", e.op), 64'(result), 64'(e.res));
                checkOutput($sformatf("zero_op%0h", e.op), 64'(zero), 64'(e.zf));
                checkOutput($sformatf("latency_op%0h", e.op), 64'(cycleCnt - e.issue),
                            64'(e.lat));
                lastRes  = e.res;
                lastZero = e.zf;
            end
        end else begin
            checkOutput("hold_result", 64'(result), 64'(lastRes));
            checkOutput("hold_zero", 64'(zero), 64'(lastZero));
        end
    end

    // Issue one request at the current negedge and record what it must return.
    task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
        expect_t e;
        start      = 1'b1;
        ALUcontrol = op;
        in1        = a;
        in2        = b;
        e.res   = refModel(op, a, b);
        e.zf    = (e.res == '0);
        e.issue = cycleCnt;
        e.lat   = isIterOp(op) ? W + 1 : 1;
        e.op    = op;
        expQ.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for done; while busy, throw ignored requests and
    // scrambled operands at the unit to prove they do not disturb it.
    task automatic waitDone(output int busyCnt);
        busyCnt = 0;
        for (int i = 0; i < W + 5; i++) begin
            if (done === 1'b1) begin
                start = 1'b0;
                return;
            end
            if (busy === 1'b1) begin
                busyCnt++;
                start      = 1'($urandom_range(0, 1));
                ALUcontrol = 4'($urandom);
                in1        = $urandom;
                in2        = $urandom;
            end
            @(negedge clk);
        end
        start = 1'b0;
        total++;
        bad++;
        $display("[TB] FAIL done_timeout: got no done within %0d cycles, wanted one", W + 5);
    endtask

    task automatic runOp(input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        int nb;
        applyStimulus(op, a, b);
        waitDone(nb);
        checkOutput($sformatf("busy_cycles_op%0h", op), 64'(nb),
                    64'(isIterOp(op) ? W : 0));
    endtask

    function automatic logic [W-1:0] randOperand();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return W'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Guard against a hung design.
    initial begin
        #900000;
        $display("[TB] FAIL watchdog: got no finish, wanted test end before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: reset, directed cases, mid-run reset, random traffic.
    initial begin
        logic [3:0] opList[10];
        opList = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd3, 4'd15};
        rst        = 1'b1;
        start      = 1'b0;
        ALUcontrol = 4'd0;
        in1        = '0;
        in2        = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_busy", 64'(busy), 64'(0));
        checkOutput("idle_done", 64'(done), 64'(0));

        runOp(4'b0010, 32'd5, 32'd7);
        runOp(4'b0110, 32'h10, 32'h10);
        runOp(4'b0111, 32'hFFFF_FFFF, 32'd1);
        runOp(4'b0111, 32'd1, 32'hFFFF_FFFF);
        runOp(4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00);
        runOp(4'b0001, 32'h0000_0000, 32'h0000_0000);
        runOp(4'b1000, 32'h0001_0003, 32'h0001_0002);
        runOp(4'b1001, 32'd100, 32'd7);
        runOp(4'b1010, 32'd100, 32'd7);
        runOp(4'b1001, 32'd9, 32'd0);
        runOp(4'b1010, 32'd9, 32'd0);
        runOp(4'b1000, 32'hF0, 32'h3C);
        runOp(4'b1111, 32'hFF00_FF00, 32'h0F0F_0F0F);
        repeat (2) @(negedge clk);

        $display("[TB] reset during an iterative operation");
        applyStimulus(4'b1000, 32'h0001_0003, 32'h0001_0002);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrun_rst_busy", 64'(busy), 64'(0));
        checkOutput("midrun_rst_result", 64'(result), 64'(0));
        repeat (W + 5) @(negedge clk);

        $display("[TB] random traffic");
        for (int i = 0; i < 150; i++) begin
            runOp(opList[$urandom_range(0, 9)], randOperand(), randOperand());
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL pending_responses: got %0d outstanding, wanted 0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Parametrised, clocked successor to the single-cycle datapath ALU, used as the execute-stage arithmetic unit in the multi-cycle and pipelined CPU variants. It accepts one operation per `start` pulse and performs AND, OR, ADD, SUB and SLT in one cycle. It also performs MUL, DIVU and REMU iteratively over WIDTH cycles. Results are registered and held, and completion is signalled with a one-cycle `done` pulse.

## Interface
- `WIDTH`, default 32: operand and result width in bits; legal range 4..64.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request strobe; sampled on the rising edge when the unit is not busy.
- `ALUcontrol` input 4: operation code, sampled with `start`.
- `in1` input WIDTH: operand A, sampled with `start`.
- `in2` input WIDTH: operand B, sampled with `start`.
- `result` output WIDTH: registered result, held until the next completion.
- `zero` output 1: registered flag, equal to (`result` == 0) for every operation.
- `busy` output 1: high while an iterative operation runs; `start` is ignored while it is high.
- `done` output 1: one-cycle pulse when `result` and `zero` update.

## Operation
- Opcodes:
  - 0000 AND.
  - 0001 OR.
  - 0010 ADD, modulo 2^WIDTH, carry discarded.
  - 0110 SUB, modulo 2^WIDTH.
  - 0111 SLT, signed two's-complement compare: `result` = 1 if in1 < in2, else 0, zero-extended.
  - 1000 MUL: low WIDTH bits of the unsigned product.
  - 1001 DIVU: unsigned quotient.
  - 1010 REMU: unsigned remainder.
  - Any other code executes AND.
- States: IDLE, RUN, DONE.
  - IDLE or DONE with `start` and a single-cycle opcode: compute, register the result, go to DONE.
  - IDLE or DONE with `start` and an iterative opcode: latch operands, clear the iteration counter, go to RUN.
  - IDLE or DONE without `start`: go to IDLE (DONE lasts exactly one cycle).
  - RUN: one shift-add step (MUL) or one restoring shift-subtract step (DIVU/REMU) per cycle. After exactly WIDTH steps, register the result and go to DONE.
- Outputs: `busy` = (state == RUN); `done` = (state == DONE).
- `start` while in RUN is ignored; nothing is queued.
- Divide by zero: takes the normal WIDTH-cycle latency. DIVU returns all ones; REMU returns in1. No exception is raised.
- Operands that change after acceptance do not affect the operation in flight.
- `zero` is recomputed together with `result`, never combinationally from the inputs.

## Timing
- Reset: state IDLE, `result` = 0, `zero` = 1, `busy` = 0, `done` = 0, iteration counter = 0.
- Reset asserted in any state, including mid-RUN, aborts the operation and forces the reset values on the next edge. It has priority over `start`.
- Single-cycle ops: `start` sampled at edge N → `result`, `zero` and `done` valid after edge N+1.
- Iterative ops: `start` sampled at edge N → `busy` high after edges N+1 through N+WIDTH → `done` and the new `result` after edge N+WIDTH+1.
  - Latency is exactly WIDTH+1 cycles, independent of operand values.
- Back-to-back: `start` in the DONE cycle is accepted, which gives a throughput of one single-cycle op per cycle.
- `result` and `zero` change only in the cycle `done` is high; otherwise they hold their values.

## Configuration
- `ALU_MULDIV_EN`:
  - Defined: opcodes 1000/1001/1010 execute iteratively as above.
  - Undefined: the RUN state, counter and shift registers are not compiled. Those opcodes fall to the default (AND, single cycle) and `busy` is tied to 0.

## Test plan
- Reset then idle: `result`=0, `zero`=1, `done`=0, `busy`=0. `start` with 0010, in1=5, in2=7 → `result`=12, `zero`=0, `done` for exactly one cycle.
- SUB 0x10−0x10 → `result`=0, `zero`=1. SLT with in1=0xFFFFFFFF, in2=1 → `result`=1. SLT with in1=1, in2=0xFFFFFFFF → `result`=0.
- MUL 0x0001_0003 × 0x0001_0002 → `result`=0x0005_0006 (low 32 bits) and `busy` high for exactly 32 cycles. Pulsing `start` while busy changes nothing.
- DIVU 100/7 → 14 and REMU 100/7 → 2, each `done` 33 cycles after `start`. DIVU 9/0 → 0xFFFFFFFF; REMU 9/0 → 9.
- Assert `rst` at RUN cycle 10 of a MUL → next edge `busy`=0, `result`=0, `zero`=1, and `done` never pulses.
- Build without `ALU_MULDIV_EN`: opcode 1000 with 0xF0/0x3C → `result`=0x30 one cycle later, `busy` stays 0. Repeat with WIDTH=8 and `ALU_MULDIV_EN` defined: MUL 15×17 → 0xFF after 9 cycles.
